// File: rtl/seg7_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment driver.
package seg7_pkg;

    localparam int NUM_DIG = 6;

    typedef logic [2:0] dig_idx_t;

    // Active-high g..a patterns; element 0 is hex digit 0.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble plus decimal point to active-high segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, SEG_PAT[nib]};

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed seven-segment scanner with frame-synchronous shadow
// register, per-slot anti-ghost blanking and optional leading-zero suppression.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLANK_CYC   = 2,
    parameter bit SEL_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        data_in,
    input  logic [NUM_DIG-1:0] dp_in,
    input  logic               blank_en,
    output logic [NUM_DIG-1:0] sel,
    output logic [7:0]         seg
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam dig_idx_t IDX_MAX = dig_idx_t'(NUM_DIG - 1);
    localparam logic [NUM_DIG-1:0] SEL_OFF = {NUM_DIG{SEL_ACT_LOW}};
    localparam logic [7:0]         SEG_OFF = {8{SEG_ACT_LOW}};

    logic [CW-1:0]      cnt_r;
    dig_idx_t           idx_r;
    logic               init_r;
    logic [23:0]        data_sh_r;
    logic [NUM_DIG-1:0] dp_sh_r;
    logic [NUM_DIG-1:0] sel_r;
    logic [7:0]         seg_r;

    logic               tick_s;
    logic               load_s;
    logic [NUM_DIG-1:0] lz_mask_s;
    logic [3:0]         nib_s;
    logic               dp_s;
    logic               blank_s;
    logic [7:0]         dec_s;
    logic               lit_s;
    logic [NUM_DIG-1:0] sel_act_s;
    logic [7:0]         seg_act_s;

    assign tick_s = (cnt_r == CNT_MAX);
    assign load_s = !init_r || (tick_s && (idx_r == IDX_MAX));
    assign lit_s  = (cnt_r >= BLANK_END);

    // Slot counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= 3'd0;
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= (idx_r == IDX_MAX) ? 3'd0 : idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Shadow register: one-shot load after reset, then once per frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_r    <= 1'b0;
            data_sh_r <= 24'h000000;
            dp_sh_r   <= {NUM_DIG{1'b0}};
        end else begin
            init_r <= 1'b1;
            if (load_s) begin
                data_sh_r <= data_in;
                dp_sh_r   <= dp_in;
            end
        end
    end

    // Leading-zero mask: digit i blanks while it and every digit left of it is zero.
    always_comb begin
        logic zero_run;
        zero_run  = blank_en;
        lz_mask_s = {NUM_DIG{1'b0}};
        for (int i = 0; i < NUM_DIG; i++) begin
            zero_run     = zero_run && (data_sh_r[23-4*i -: 4] == 4'h0);
            lz_mask_s[i] = (i < NUM_DIG - 1) ? zero_run : 1'b0;
        end
    end

    // Select the nibble, decimal point and blank flag of the digit in the current slot.
    always_comb begin
        nib_s   = 4'h0;
        dp_s    = 1'b0;
        blank_s = 1'b1;
        case (idx_r)
            3'd0: begin nib_s = data_sh_r[23:20]; dp_s = dp_sh_r[0]; blank_s = lz_mask_s[0]; end
            3'd1: begin nib_s = data_sh_r[19:16]; dp_s = dp_sh_r[1]; blank_s = lz_mask_s[1]; end
            3'd2: begin nib_s = data_sh_r[15:12]; dp_s = dp_sh_r[2]; blank_s = lz_mask_s[2]; end
            3'd3: begin nib_s = data_sh_r[11:8];  dp_s = dp_sh_r[3]; blank_s = lz_mask_s[3]; end
            3'd4: begin nib_s = data_sh_r[7:4];   dp_s = dp_sh_r[4]; blank_s = lz_mask_s[4]; end
            3'd5: begin nib_s = data_sh_r[3:0];   dp_s = dp_sh_r[5]; blank_s = lz_mask_s[5]; end
            default: begin nib_s = 4'h0; dp_s = 1'b0; blank_s = 1'b1; end
        endcase
    end

    seg7_decode u_dec (
        .nib (nib_s),
        .dp  (dp_s),
        .seg (dec_s)
    );

    // Active-high next output values; segments also go dark in the anti-ghost window.
    always_comb begin
        sel_act_s = {NUM_DIG{1'b0}};
        seg_act_s = 8'h00;
        if (lit_s) begin
            sel_act_s = 6'b000001 << idx_r;
            seg_act_s = blank_s ? 8'h00 : dec_s;
        end else begin
            sel_act_s = {NUM_DIG{1'b0}};
            seg_act_s = 8'h00;
        end
    end

    // Output registers with polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r <= SEL_OFF;
            seg_r <= SEG_OFF;
        end else begin
            sel_r <= sel_act_s ^ SEL_OFF;
            seg_r <= seg_act_s ^ SEG_OFF;
        end
    end

    assign sel = sel_r;
    assign seg = seg_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: vector table, hand sequences and random
// stimulus against a frame-level reference model.
module tb_seg7_scan;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = 6 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] data_in = 24'h000000;
    logic [5:0]  dp_in = 6'h00;
    logic        blank_en = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    seg7_scan #(
        .CLK_DIV     (CLK_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .SEL_ACT_LOW (1'b1),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_en (blank_en),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: clock edges since reset release and the word shown this frame.
    int unsigned n = 0;
    logic [23:0] m_sh = 24'h000000;
    logic [5:0]  m_dp = 6'h00;
    int          cur_d = 0;
    bit          cur_lit = 1'b0;

    typedef struct {
        logic [23:0]     data;
        logic [5:0]      dp;
        logic            ben;
        logic [5:0][7:0] exp_seg;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic void model_out(input int unsigned k, input logic [23:0] sh,
                                      input logic [5:0] shdp, input logic ben,
                                      output logic [5:0] es, output logic [7:0] eg,
                                      output bit lit, output int d);
        int c;
        logic [23:0] upper;
        logic [3:0] nib;
        c     = int'((k - 1) % CLK_DIV);
        d     = int'(((k - 1) / CLK_DIV) % 6);
        lit   = (c >= BLANK_CYC);
        upper = sh >> (4 * (5 - d));
        nib   = upper[3:0];
        es    = lit ? ~(6'b000001 << d) : 6'h3F;
        if (!lit || (ben && upper == 24'h0 && d < 5))
            eg = 8'hFF;
        else
            eg = ~{shdp[d], pat[nib]};
    endfunction

    task automatic step();
        logic [5:0] es;
        logic [7:0] eg;
        bit lit;
        int d;
        @(posedge clk);
        n++;
        model_out(n, m_sh, m_dp, blank_en, es, eg, lit, d);
        if (n == 1 || (n % FRAME) == 0) begin
            m_sh = data_in;
            m_dp = dp_in;
        end
        cur_d   = d;
        cur_lit = lit;
        #1;
        check("model_sel", {2'b00, sel}, {2'b00, es});
        if (lit) check("model_seg", seg, eg);
    endtask

    task automatic sync_frame();
        int guard = 0;
        while ((n % FRAME) != 0 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        checks++;
        if ((n % FRAME) != 0) begin
            errors++;
            $display("FAIL sync_frame: edge %0d not on frame boundary", n);
        end
    endtask

    initial begin
        vecs[0] = '{data: 24'h012345, dp: 6'b000000, ben: 1'b0,
                    exp_seg: {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
        vecs[1] = '{data: 24'hABCDEF, dp: 6'b000000, ben: 1'b0,
                    exp_seg: {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88}};
        vecs[2] = '{data: 24'h000A0F, dp: 6'b000000, ben: 1'b1,
                    exp_seg: {8'h8E, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{data: 24'h000000, dp: 6'b000000, ben: 1'b1,
                    exp_seg: {8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{data: 24'h012345, dp: 6'b000100, ben: 1'b0,
                    exp_seg: {8'h92, 8'h99, 8'hB0, 8'h24, 8'hF9, 8'hC0}};

        // Reset held, outputs inactive.
        data_in  = vecs[0].data;
        dp_in    = vecs[0].dp;
        blank_en = vecs[0].ben;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", {2'b00, sel}, 8'h3F);
        check("reset_seg", seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_sh = 24'h0; m_dp = 6'h0;
        step();
        check("first_blank_sel", {2'b00, sel}, 8'h3F);
        step();
        check("first_lit_sel", {2'b00, sel}, 8'h3E);
        check("first_lit_seg", seg, 8'hC0);

        // Table rows, next row's word preloaded while digit 2 is lit.
        for (int r = 0; r < 5; r++) begin
            sync_frame();
            blank_en = vecs[r].ben;
            for (int j = 0; j < FRAME; j++) begin
                step();
                if (cur_lit) begin
                    check("tbl_sel", {2'b00, sel}, {2'b00, ~(6'b000001 << cur_d)});
                    check("tbl_seg", seg, vecs[r].exp_seg[cur_d]);
                end
                if (j == 9 && r < 4) begin
                    data_in = vecs[r + 1].data;
                    dp_in   = vecs[r + 1].dp;
                end
            end
        end

        // Random stimulus with biased leading zeros.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                data_in = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
                dp_in   = 6'($urandom);
            end
            if ($urandom_range(0, 15) == 0) blank_en = 1'($urandom);
            step();
        end

        // Asynchronous reset while digit 3 is lit.
        begin
            int guard = 0;
            while ((n % FRAME) != 15 && guard < 2 * FRAME) begin
                step();
                guard++;
            end
        end
        check("mid_pre_sel", {2'b00, sel}, 8'h37);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", {2'b00, sel}, 8'h3F);
        check("async_rst_seg", seg, 8'hFF);
        data_in  = 24'h9A0000;
        dp_in    = 6'h00;
        blank_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0; m_sh = 24'h0; m_dp = 6'h0;
        step();
        step();
        check("restart_sel", {2'b00, sel}, 8'h3E);
        check("restart_seg", seg, 8'h90);
        for (int k = 0; k < 2 * FRAME; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
